// File: rtl/axis_in_pkg.sv
// axis_in_pkg: shared FSM state encodings and a constant clog2 helper for the AXIS ingress buffer
package axis_in_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word fall-through FIFO with full/empty/level flags
// Ports: i_push/i_wdata write side, i_pop/o_rdata read side (o_rdata=0 when empty),
//   o_full/o_empty/o_level occupancy. Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo
  import axis_in_pkg::*;
#(
  parameter int W = 33,
  parameter int D = 4,
  localparam int AW = clog2(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);
  logic [W-1:0] r_mem [D];
  logic [AW:0]  r_wp, r_rp;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop) r_rp <= r_rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (i_push) r_mem[r_wp[AW-1:0]] <= i_wdata;
  assign o_empty = r_wp == r_rp;
  assign o_full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
  assign o_level = r_wp - r_rp;
  assign o_rdata = o_empty ? '0 : r_mem[r_rp[AW-1:0]];
endmodule

// File: rtl/axis_in_buf.sv
// axis_in_buf: AXI-Stream ingress stage buffering one frame per ap_start for the FIR core
// Ports: ap_start/data_len frame control; tvalid/tdata/tlast/tready AXIS slave;
//   strm_data/strm_valid/strm_last/fir_ready FIR-side stream; axis_finish end pulse,
//   len_err tlast/length mismatch, busy, fill_level FIFO occupancy.
module axis_in_buf
  import axis_in_pkg::*;
#(
  parameter int pDATA_WIDTH = 32,
  parameter int pDEPTH      = 4,
  parameter int pLEN_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ap_start,
  input  logic [pLEN_WIDTH-1:0]    data_len,
  input  logic                     tvalid,
  input  logic [pDATA_WIDTH-1:0]   tdata,
  input  logic                     tlast,
  output logic                     tready,
  output logic [pDATA_WIDTH-1:0]   strm_data,
  output logic                     strm_valid,
  output logic                     strm_last,
  input  logic                     fir_ready,
  output logic                     axis_finish,
  output logic                     len_err,
  output logic                     busy,
  output logic [clog2(pDEPTH):0]   fill_level
);
  state_t                r_state, w_next;
  logic [pLEN_WIDTH-1:0] r_cnt, r_len;
  logic                  r_err, r_fin;
  logic                  w_full, w_empty, w_push, w_pop, w_at_len, w_end, w_start;
  logic [pDATA_WIDTH:0]  w_head;
  assign w_start     = r_state == IDLE && ap_start;
  assign tready      = r_state == RUN && !w_full;
  assign w_push      = tvalid && tready;
  assign w_pop       = !w_empty && fir_ready;
  assign w_at_len    = r_len != '0 && r_cnt == r_len - 1'b1;
  // a frame ends on whichever comes first: tlast or the programmed length
  assign w_end       = tlast || w_at_len;
  assign strm_valid  = !w_empty;
  assign strm_data   = w_head[pDATA_WIDTH-1:0];
  assign strm_last   = w_head[pDATA_WIDTH];
  assign busy        = r_state != IDLE;
  assign axis_finish = r_fin;
  assign len_err     = r_err;
  always_comb begin
    w_next = r_state;
    w_next = w_start ? RUN :
             (r_state == RUN && w_push && w_end) ? DRAIN :
             (r_state == DRAIN && w_pop && strm_last) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_err   <= 1'b0;
      r_fin   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fin   <= r_state == DRAIN && w_pop && strm_last;
      if (w_start) begin
        r_len <= data_len;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (w_push) begin
        // saturate so tlast-only frames longer than the counter range never alias
        r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
        r_err <= r_err | (r_len != '0 && (tlast ^ w_at_len));
      end
    end
  sync_fifo #(.W(pDATA_WIDTH + 1), .D(pDEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({w_end, tdata}),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (fill_level)
  );
endmodule

// File: tb/tb_axis_in_buf.sv
// tb_axis_in_buf: directed self-checking bench for axis_in_buf
module tb_axis_in_buf;
  logic        clk, rst_n, ap_start, tvalid, tlast, tready, strm_valid, strm_last, fir_ready;
  logic        axis_finish, len_err, busy;
  logic [15:0] data_len;
  logic [31:0] tdata, strm_data;
  logic [2:0]  fill_level;
  int          checks = 0, failures = 0, fin_cnt = 0, fin_busy = 0;
  bit          rnd = 0;
  logic [31:0] got[$], exp_q[$];
  logic        lst[$];

  axis_in_buf #(.pDATA_WIDTH(32), .pDEPTH(4), .pLEN_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .ap_start(ap_start), .data_len(data_len),
    .tvalid(tvalid), .tdata(tdata), .tlast(tlast), .tready(tready),
    .strm_data(strm_data), .strm_valid(strm_valid), .strm_last(strm_last),
    .fir_ready(fir_ready), .axis_finish(axis_finish), .len_err(len_err),
    .busy(busy), .fill_level(fill_level)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n) begin
      if (strm_valid && fir_ready) begin
        got.push_back(strm_data);
        lst.push_back(strm_last);
      end
      if (axis_finish) begin
        fin_cnt++;
        if (busy) fin_busy++;
      end
    end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] len);
    ap_start = 1;
    data_len = len;
    tick();
    ap_start = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    tvalid = 1;
    tdata = d;
    tlast = l;
    n = 0;
    while (!tready && n < 50) begin
      tick();
      n++;
      if (rnd) fir_ready = 1'($urandom_range(0, 1));
    end
    chk($sformatf("accept_%0d", d), tready, 1);
    tick();
    tvalid = 0;
    if (rnd) fir_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle(input string t);
    int n;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk({t, "_idle"}, busy, 0);
    tick();
  endtask

  task automatic clear();
    got.delete();
    lst.delete();
    fin_cnt = 0;
    fin_busy = 0;
  endtask

  task automatic chk_q(input string t);
    chk({t, "_count"}, got.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got.size()) begin
        chk($sformatf("%s_data%0d", t, i), got[i], exp_q[i]);
        chk($sformatf("%s_last%0d", t, i), lst[i], i == exp_q.size() - 1);
      end
    chk({t, "_finish_pulses"}, fin_cnt, 1);
    chk({t, "_finish_busy"}, fin_busy, 0);
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_tready"}, tready, 0);
    chk({t, "_strm_valid"}, strm_valid, 0);
    chk({t, "_strm_last"}, strm_last, 0);
    chk({t, "_strm_data"}, strm_data, 0);
    chk({t, "_axis_finish"}, axis_finish, 0);
    chk({t, "_len_err"}, len_err, 0);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_fill"}, fill_level, 0);
  endtask

  initial begin
    rst_n = 0; ap_start = 0; data_len = 0; tvalid = 0; tdata = 0; tlast = 0; fir_ready = 1;
    repeat (3) tick();
    chk_reset("rst");
    rst_n = 1;
    tick();
    chk_reset("post_rst");

    // 1: length 5 with matching tlast
    clear();
    start(5);
    chk("t1_busy", busy, 1);
    tvalid = 1; tdata = 1; tlast = 0;
    chk("t1_no_bypass", strm_valid, 0);
    send(1, 0);
    chk("t1_lat_valid", strm_valid, 1);
    chk("t1_lat_data", strm_data, 1);
    send(2, 0); send(3, 0); send(4, 0); send(5, 1);
    chk("t1_tready_drain", tready, 0);
    wait_idle("t1");
    exp_q = '{1, 2, 3, 4, 5};
    chk_q("t1");
    chk("t1_len_err", len_err, 0);
    chk("t1_empty_data", strm_data, 0);

    // 2: backpressure fills FIFO, ap_start in RUN ignored
    clear();
    fir_ready = 0;
    start(8);
    send(11, 0); send(12, 0); send(13, 0); send(14, 0);
    chk("t2_full_tready", tready, 0);
    chk("t2_full_fill", fill_level, 4);
    start(1);
    repeat (4) tick();
    chk("t2_hold_fill", fill_level, 4);
    chk("t2_hold_tready", tready, 0);
    chk("t2_hold_busy", busy, 1);
    fir_ready = 1;
    send(15, 0); send(16, 0); send(17, 0); send(18, 1);
    wait_idle("t2");
    exp_q = '{11, 12, 13, 14, 15, 16, 17, 18};
    chk_q("t2");
    chk("t2_len_err", len_err, 0);

    // 3: early tlast
    clear();
    start(4);
    send(21, 0); send(22, 1);
    wait_idle("t3");
    exp_q = '{21, 22};
    chk_q("t3");
    chk("t3_len_err", len_err, 1);

    // 4: length reached before tlast; extra beats blocked
    clear();
    start(3);
    chk("t4_err_cleared", len_err, 0);
    send(31, 0); send(32, 0); send(33, 0);
    tvalid = 1; tdata = 34; tlast = 0;
    chk("t4_drain_tready", tready, 0);
    wait_idle("t4");
    chk("t4_idle_tready", tready, 0);
    chk("t4_idle_fill", fill_level, 0);
    tvalid = 0;
    exp_q = '{31, 32, 33};
    chk_q("t4");
    chk("t4_len_err", len_err, 1);

    // 5: tlast-only frame with random gaps and backpressure
    clear();
    start(0);
    rnd = 1;
    for (int i = 0; i < 7; i++) begin
      repeat ($urandom_range(0, 2)) begin
        fir_ready = 1'($urandom_range(0, 1));
        tick();
      end
      send(41 + i, i == 6);
    end
    rnd = 0;
    fir_ready = 1;
    wait_idle("t5");
    exp_q = '{41, 42, 43, 44, 45, 46, 47};
    chk_q("t5");
    chk("t5_len_err", len_err, 0);

    // 6: reset mid-frame then a clean 2-beat frame
    clear();
    fir_ready = 0;
    start(5);
    send(51, 0); send(52, 0); send(53, 0);
    chk("t6_fill3", fill_level, 3);
    rst_n = 0;
    #1;
    chk_reset("t6_rst");
    tick();
    rst_n = 1;
    tick();
    chk_reset("t6_post");
    clear();
    fir_ready = 1;
    start(2);
    send(61, 0); send(62, 1);
    wait_idle("t6");
    exp_q = '{61, 62};
    chk_q("t6");
    chk("t6_len_err", len_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
